// File: rtl/merge_pulse_scheduler.sv
// Round-robin scheduler merging two toggle-encoded pulse streams onto one spaced output.
// Optional statistics counters (emit_cnt, drop_cnt) are built when MERGE_SCHED_STATS_EN is defined.
module merge_pulse_scheduler #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr_drop,
  output logic             out,
  output logic [CNT_W-1:0] a_pend,
  output logic [CNT_W-1:0] b_pend,
  output logic             drop_a,
  output logic             drop_b,
`ifdef MERGE_SCHED_STATS_EN
  output logic [15:0]      emit_cnt,
  output logic [15:0]      drop_cnt,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] PendMax = '1;
  localparam logic [3:0]       GapLoad = 4'(MIN_GAP - 1);

  typedef enum logic {SrcA, SrcB} src_e;

  logic             a_prev_q, b_prev_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic             drop_a_q, drop_a_d, drop_b_q, drop_b_d;
  logic [3:0]       gap_q, gap_d;
  src_e             rr_last_q, rr_last_d;

  logic a_pulse, b_pulse;
  logic issue, contend, serve_a, serve_b;
  logic a_drop, b_drop;

  // Returns {dropped, next count}; a pulse is only refused when full and not draining this edge.
  function automatic logic [CNT_W:0] pend_next(input logic [CNT_W-1:0] pend, input logic pulse,
                                               input logic serve);
    logic take;
    logic [CNT_W-1:0] nxt;
    take = pulse && (serve || (pend != PendMax));
    unique case ({take, serve})
      2'b10:   nxt = pend + 1'b1;
      2'b01:   nxt = pend - 1'b1;
      default: nxt = pend;
    endcase
    return {pulse && !take, nxt};
  endfunction

  always_comb begin
    a_pulse = a_in ^ a_prev_q;
    b_pulse = b_in ^ b_prev_q;
    contend = (a_pend_q != '0) && (b_pend_q != '0);
    issue   = (gap_q == '0) && ((a_pend_q != '0) || (b_pend_q != '0));
    serve_a = issue && (a_pend_q != '0) && (!contend || (rr_last_q == SrcB));
    serve_b = issue && !serve_a;

    {a_drop, a_pend_d} = pend_next(a_pend_q, a_pulse, serve_a);
    {b_drop, b_pend_d} = pend_next(b_pend_q, b_pulse, serve_b);

    // A fresh drop outranks a simultaneous clear.
    drop_a_d = a_drop | (drop_a_q & ~clr_drop);
    drop_b_d = b_drop | (drop_b_q & ~clr_drop);

    out_d = out_q ^ issue;

    if (issue) begin
      gap_d = GapLoad;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 4'd1;
    end else begin
      gap_d = gap_q;
    end

    // Arbitration pointer only moves when both requesters actually competed.
    rr_last_d = rr_last_q;
    if (issue && contend) begin
      rr_last_d = serve_a ? SrcA : SrcB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev_q  <= a_in;
      b_prev_q  <= b_in;
      out_q     <= 1'b0;
      a_pend_q  <= '0;
      b_pend_q  <= '0;
      drop_a_q  <= 1'b0;
      drop_b_q  <= 1'b0;
      gap_q     <= '0;
      rr_last_q <= SrcB;
    end else begin
      a_prev_q  <= a_in;
      b_prev_q  <= b_in;
      out_q     <= out_d;
      a_pend_q  <= a_pend_d;
      b_pend_q  <= b_pend_d;
      drop_a_q  <= drop_a_d;
      drop_b_q  <= drop_b_d;
      gap_q     <= gap_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign out    = out_q;
  assign a_pend = a_pend_q;
  assign b_pend = b_pend_q;
  assign drop_a = drop_a_q;
  assign drop_b = drop_b_q;
  assign busy   = (a_pend_q != '0) || (b_pend_q != '0) || (gap_q != '0);

`ifdef MERGE_SCHED_STATS_EN
  logic [15:0] emit_cnt_q, emit_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    emit_cnt_d = emit_cnt_q + {15'd0, issue};
    drop_sum   = {1'b0, drop_cnt_q} + {16'd0, a_drop} + {16'd0, b_drop};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      emit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      emit_cnt_q <= emit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign emit_cnt = emit_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_merge_pulse_scheduler.sv
// Randomized scoreboard bench for merge_pulse_scheduler; a queue-based reference model predicts
// per-edge state and output-toggle timing, a negedge monitor compares.
module tb_merge_pulse_scheduler;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MIN_GAP = 2;
  localparam int          PMAX    = (1 << CNT_W) - 1;

  logic clk, rst, a_in, b_in, clr_drop;
  logic out, drop_a, drop_b, busy;
  logic [CNT_W-1:0] a_pend, b_pend;
`ifdef MERGE_SCHED_STATS_EN
  logic [15:0] emit_cnt, drop_cnt;
`endif

  merge_pulse_scheduler #(.CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .clr_drop (clr_drop),
    .out      (out),
    .a_pend   (a_pend),
    .b_pend   (b_pend),
    .drop_a   (drop_a),
    .drop_b   (drop_b),
`ifdef MERGE_SCHED_STATS_EN
    .emit_cnt (emit_cnt),
    .drop_cnt (drop_cnt),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n; int pa; int pb; bit da; bit db; bit busy; bit out; int emit; int drop;
  } stat_t;

  stat_t sq[$];
  int    tq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model state: queued pulse counts and earliest edge allowed to emit.
  int m_pa, m_pb, m_next_ok, m_n, m_emit, m_drop;
  bit m_last_b, m_prev_a, m_prev_b, m_out, m_da, m_db;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model();
    bit pla, plb, srv_a, lost_a, lost_b;
    stat_t s;
    if (rst) begin
      if (m_out) tq.push_back(m_n);
      m_pa = 0; m_pb = 0; m_out = 0; m_da = 0; m_db = 0; m_last_b = 1;
      m_next_ok = 0; m_emit = 0; m_drop = 0;
      m_prev_a = a_in; m_prev_b = b_in;
    end else begin
      pla = (a_in != m_prev_a);
      plb = (b_in != m_prev_b);
      m_prev_a = a_in; m_prev_b = b_in;
      if (m_n >= m_next_ok && (m_pa > 0 || m_pb > 0)) begin
        if (m_pa > 0 && m_pb > 0) begin
          srv_a = m_last_b;
          m_last_b = !srv_a;
        end else begin
          srv_a = (m_pa > 0);
        end
        if (srv_a) m_pa--; else m_pb--;
        m_out = !m_out;
        m_next_ok = m_n + MIN_GAP;
        m_emit = (m_emit + 1) % 65536;
        tq.push_back(m_n);
      end
      lost_a = 0; lost_b = 0;
      if (pla) begin if (m_pa < PMAX) m_pa++; else lost_a = 1; end
      if (plb) begin if (m_pb < PMAX) m_pb++; else lost_b = 1; end
      m_da = lost_a ? 1'b1 : (clr_drop ? 1'b0 : m_da);
      m_db = lost_b ? 1'b1 : (clr_drop ? 1'b0 : m_db);
      m_drop = m_drop + int'(lost_a) + int'(lost_b);
      if (m_drop > 65535) m_drop = 65535;
    end
    s.n = m_n; s.pa = m_pa; s.pb = m_pb; s.da = m_da; s.db = m_db; s.out = m_out;
    s.busy = (m_pa > 0) || (m_pb > 0) || (m_n + 1 < m_next_ok);
    s.emit = m_emit; s.drop = m_drop;
    sq.push_back(s);
  endtask

  task automatic step(input bit pa, input bit pb, input bit clr, input bit r);
    a_in = a_in ^ pa;
    b_in = b_in ^ pb;
    clr_drop = clr;
    rst = r;
    @(posedge clk);
    model();
    m_n++;
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, 0, 0);
  endtask

  // Monitor: one predicted state per edge, plus timing of every output level change.
  logic out_seen = 1'b0;
  always @(negedge clk) begin
    stat_t s;
    int te;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("a_pend", int'(a_pend), s.pa);
      chk("b_pend", int'(b_pend), s.pb);
      chk("drop_a", int'(drop_a), int'(s.da));
      chk("drop_b", int'(drop_b), int'(s.db));
      chk("busy", int'(busy), int'(s.busy));
      chk("out", int'(out), int'(s.out));
`ifdef MERGE_SCHED_STATS_EN
      chk("emit_cnt", int'(emit_cnt), s.emit);
      chk("drop_cnt", int'(drop_cnt), s.drop);
`endif
      if (out !== out_seen) begin
        if (tq.size() == 0) begin
          chk("unexpected_toggle_edge", s.n, -1);
        end else begin
          te = tq.pop_front();
          chk("toggle_edge", s.n, te);
        end
        out_seen = out;
      end
    end
  end

  initial begin
    int dens;
    a_in = 1'b1; b_in = 1'b0; clr_drop = 1'b0; rst = 1'b1;
    m_n = 0;
    // Reset with A high, then hold: nothing should be emitted.
    repeat (3) step(0, 0, 0, 1);
    idle(6);
    // Single A pulse on an idle block.
    step(1, 0, 0, 0);
    idle(5);
    // Simultaneous pulses twice: A first, then the next contention goes to B.
    step(1, 1, 0, 0);
    idle(6);
    step(1, 1, 0, 0);
    idle(6);
    // A every cycle for 40 cycles: saturation and drops, then clear.
    repeat (40) step(1, 0, 0, 0);
    idle(40);
    step(0, 0, 1, 0);
    idle(3);
    // Saturate B, then a drop coinciding with clr_drop keeps the flag.
    repeat (40) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    idle(40);
    // Backlog on both, then reset mid-operation and a fresh pulse.
    repeat (10) step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    idle(5);
    // Randomized traffic with varying density, sporadic clears and resets.
    for (int blk = 0; blk < 20; blk++) begin
      dens = $urandom_range(5, 100);
      for (int i = 0; i < 80; i++) begin
        step($urandom_range(0, 99) < dens, $urandom_range(0, 99) < dens,
             $urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0);
      end
    end
    idle(80);
    @(negedge clk);
    #1;
    chk("pending_toggles_left", tq.size(), 0);
    chk("pending_states_left", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/merge_pulse_scheduler.md
Name: merge_pulse_scheduler

Overview:
- Clocked arbiter/scheduler in front of a shared RSFQ merge resource.
- Two requesters deliver toggle-encoded pulses; each edge of an input is one pulse.
- Block queues the pulses and reissues them on one toggle-encoded output.
- Output pulses are spaced at least MIN_GAP cycles apart, so downstream merge/receiver timing is never violated and near-coincident pulses are not lost.

Parameters:
- CNT_W, 4: width of each per-input pending counter. Max backlog per input is 2^CNT_W-1.
- MIN_GAP, 2: minimum clock cycles between consecutive output pulses. Legal range 1..15; 1 means back-to-back emission every cycle.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- a_in  input  1  requester A pulse stream, toggle-encoded
- b_in  input  1  requester B pulse stream, toggle-encoded
- clr_drop  input  1  clears sticky drop flags
- out  output  1  merged pulse stream, toggle-encoded, registered
- a_pend  output  CNT_W  pulses queued for A
- b_pend  output  CNT_W  pulses queued for B
- drop_a  output  1  sticky: an A pulse was lost to saturation
- drop_b  output  1  sticky: a B pulse was lost to saturation
- busy  output  1  high when a_pend!=0, b_pend!=0 or gap_cnt!=0

Behaviour:
- Reset (rst high at an edge):
  - out=0, a_pend=b_pend=0, drop_a=drop_b=0, gap_cnt=0, rr_last=B.
  - a_prev<=a_in and b_prev<=b_in, so the input level at reset is not a pulse.
- Pulse detection:
  - A pulse is seen at an edge when a_in!=a_prev (same for B).
  - a_prev/b_prev update every edge.
  - At most one pulse per input per cycle.
- Issue decision (combinational from registered state):
  - Issue when gap_cnt==0 and (a_pend!=0 or b_pend!=0).
  - Only one requester pending: serve it.
  - Both pending: serve the one that is not rr_last, then set rr_last to the served input.
  - The first contention after reset goes to A.
- Issue effects (same edge):
  - out<=~out.
  - The served counter decrements.
  - gap_cnt<=MIN_GAP-1.
  - Otherwise gap_cnt decrements while nonzero.
- Latency:
  - A pulse detected at edge k on an idle block toggles out at edge k+1.
  - Counters only count; there is no combinational bypass.
- Counter update, per input, same edge:
  - Increment on pulse, decrement on issue.
  - Both together: net unchanged, and the pulse is not dropped.
- Saturation:
  - A pulse arriving when the counter is at 2^CNT_W-1 and not being decremented that edge is discarded.
  - The counter holds, and drop_x<=1.
- Drop flags:
  - clr_drop clears both flags.
  - A new drop in the same cycle as clr_drop wins, so the flag stays 1.
- Simultaneous A and B pulses: both are queued and emitted MIN_GAP cycles apart, A first when rr_last=B.
- MIN_GAP=1: gap_cnt stays 0 and the block can emit every cycle.
- Reset mid-operation:
  - All queued pulses are discarded and no output toggle occurs on the reset edge.
  - out returns to 0; this is a level change, not an emitted pulse, and downstream must be reset together.

Optional Feature:
- Macro MERGE_SCHED_STATS_EN.
- When defined:
  - Adds output port emit_cnt, 16 bits, reset 0.
  - emit_cnt increments on every issue and wraps 0xFFFF→0.
  - Adds output port drop_cnt, 16 bits, reset 0.
  - drop_cnt increments by 1 or 2 per cycle according to how many pulses were discarded, and saturates at 0xFFFF.
  - clr_drop does not clear drop_cnt.
- When undefined:
  - Neither port nor its logic exists.
  - All other behaviour is identical.

Test Plan:
- Reset with a_in=1, b_in=0, release, hold inputs → out stays 0, busy=0, no pending count.
- Single A toggle at edge 20 → a_pend=1 after edge 20, out toggles 0→1 at edge 21, a_pend=0, busy=1 for MIN_GAP-1=1 more cycle.
- A and B toggle at the same edge, MIN_GAP=2 → out toggles at k+1 (A) and k+3 (B). Next contention serves B first.
- A toggles every cycle for 40 cycles with MIN_GAP=2 and CNT_W=4 → a_pend saturates at 15 and drop_a=1. clr_drop with no concurrent drop clears it. Total out toggles equals 40 minus dropped count.
- Reset asserted with a_pend=5 and b_pend=3 → the next edge gives pend=0 and out=0. The first post-reset pulse is emitted normally, 1 cycle later.
- MERGE_SCHED_STATS_EN defined, run the saturation scenario → emit_cnt equals the number of out toggles, drop_cnt equals the lost pulses, and drop_cnt is unchanged by clr_drop.
